// File: rtl/bsr_pkg.sv
// ============================================================================
// bsr_pkg : boundary-scan chain sizing, slice offsets and count width
// Rev 1.0
// ============================================================================
`default_nettype none

package bsr_pkg;

  localparam int N_GPIO_DEF = 15;
  localparam int N_DIN_DEF  = 18;

  // Chain layout, LSB first: [IN | OUT | OE | COMMIT]
  function automatic int bsr_len(input int n_gpio, input int n_din);
    return 3 * n_gpio + n_din + 1;
  endfunction

  function automatic int in_lo(input int n_gpio, input int n_din);
    return 0;
  endfunction

  function automatic int in_hi(input int n_gpio, input int n_din);
    return n_gpio + n_din - 1;
  endfunction

  function automatic int out_lo(input int n_gpio, input int n_din);
    return n_gpio + n_din;
  endfunction

  function automatic int out_hi(input int n_gpio, input int n_din);
    return 2 * n_gpio + n_din - 1;
  endfunction

  function automatic int oe_lo(input int n_gpio, input int n_din);
    return 2 * n_gpio + n_din;
  endfunction

  function automatic int oe_hi(input int n_gpio, input int n_din);
    return 3 * n_gpio + n_din - 1;
  endfunction

  function automatic int commit_idx(input int n_gpio, input int n_din);
    return bsr_len(n_gpio, n_din) - 1;
  endfunction

  // Count must reach BSR_LEN+1 (saturation value)
  function automatic int cnt_width(input int n_gpio, input int n_din);
    return $clog2(bsr_len(n_gpio, n_din) + 2);
  endfunction

  localparam int CNT_W_DEF = $clog2(3 * N_GPIO_DEF + N_DIN_DEF + 1 + 2);

endpackage

`default_nettype wire

// File: rtl/bsr_pad_mux.sv
// ============================================================================
// bsr_pad_mux : per-pad precedence mux highz > clamp > extest > functional
// Rev 1.0
// ============================================================================
`default_nettype none

module bsr_pad_mux (
  input  logic highz_i,
  input  logic clamp_i,
  input  logic extest_i,
  input  logic upd_o_i,
  input  logic upd_oe_i,
  input  logic core_o_i,
  input  logic core_oe_i,
  output logic pad_o_o,
  output logic pad_oe_o
);

  always_comb begin
    pad_o_o  = core_o_i;
    pad_oe_o = core_oe_i;
    if (highz_i) begin
      pad_o_o  = upd_o_i;
      pad_oe_o = 1'b0;
    end else if (clamp_i || extest_i) begin
      pad_o_o  = upd_o_i;
      pad_oe_o = upd_oe_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bsr_chain.sv
// ============================================================================
// bsr_chain : JTAG boundary-scan register with commit-gated update and
//             length check. BSR_CLAMP_EN enables the CLAMP/HIGHZ pad modes.
// Rev 1.0
// ============================================================================
`default_nettype none

module bsr_chain
  import bsr_pkg::*;
#(
  parameter int N_GPIO = N_GPIO_DEF,
  parameter int N_DIN  = N_DIN_DEF
) (
  input  logic                     tck_i,
  input  logic                     test_logic_reset_i,
  input  logic                     capture_dr_i,
  input  logic                     shift_dr_i,
  input  logic                     update_dr_i,
  input  logic                     sample_preload_select_i,
  input  logic                     extest_select_i,
  input  logic                     clamp_select_i,
  input  logic                     highz_select_i,
  input  logic                     tdi_i,
  output logic                     tdo_o,
  input  logic [N_GPIO+N_DIN-1:0]  pad_in_i,
  input  logic [N_GPIO-1:0]        core_o_i,
  input  logic [N_GPIO-1:0]        core_oe_i,
  output logic [N_GPIO-1:0]        pad_o,
  output logic [N_GPIO-1:0]        pad_oe_o,
  output logic                     len_err_o
);

  localparam int BSR_LEN    = bsr_len(N_GPIO, N_DIN);
  localparam int CNT_W      = cnt_width(N_GPIO, N_DIN);
  localparam int IN_LO      = in_lo(N_GPIO, N_DIN);
  localparam int OUT_LO     = out_lo(N_GPIO, N_DIN);
  localparam int OE_LO      = oe_lo(N_GPIO, N_DIN);
  localparam int COMMIT_IDX = commit_idx(N_GPIO, N_DIN);

  logic [BSR_LEN-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_GPIO-1:0]  upd_o_q, upd_o_d;
  logic [N_GPIO-1:0]  upd_oe_q, upd_oe_d;
  logic               len_err_q, len_err_d;
  logic               chain_sel;
  logic               highz_en;
  logic               clamp_en;

  assign chain_sel = sample_preload_select_i | extest_select_i;

`ifdef BSR_CLAMP_EN
  assign highz_en = highz_select_i;
  assign clamp_en = clamp_select_i;
`else
  logic clamp_highz_unused;
  assign clamp_highz_unused = clamp_select_i ^ highz_select_i;
  assign highz_en = 1'b0;
  assign clamp_en = 1'b0;
`endif

  // Strobe priority capture > shift > update; EXTEST wins when both selects are high
  always_comb begin
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    upd_o_d   = upd_o_q;
    upd_oe_d  = upd_oe_q;
    len_err_d = len_err_q;
    if (chain_sel) begin
      if (capture_dr_i) begin
        sr_d[IN_LO +: N_GPIO+N_DIN] = pad_in_i;
        sr_d[OUT_LO +: N_GPIO]      = extest_select_i ? upd_o_q  : core_o_i;
        sr_d[OE_LO +: N_GPIO]       = extest_select_i ? upd_oe_q : core_oe_i;
        sr_d[COMMIT_IDX]            = 1'b0;
        cnt_d                       = '0;
        len_err_d                   = 1'b0;
      end else if (shift_dr_i) begin
        sr_d = {tdi_i, sr_q[BSR_LEN-1:1]};
        if (cnt_q != CNT_W'(BSR_LEN + 1)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end else if (update_dr_i) begin
        if (cnt_q != CNT_W'(BSR_LEN)) begin
          len_err_d = 1'b1;
        end else if (sr_q[COMMIT_IDX]) begin
          upd_o_d  = sr_q[OUT_LO +: N_GPIO];
          upd_oe_d = sr_q[OE_LO +: N_GPIO];
        end
      end
    end
  end

  always_ff @(posedge tck_i or posedge test_logic_reset_i) begin
    if (test_logic_reset_i) begin
      sr_q      <= '0;
      cnt_q     <= '0;
      upd_o_q   <= '0;
      upd_oe_q  <= '0;
      len_err_q <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      upd_o_q   <= upd_o_d;
      upd_oe_q  <= upd_oe_d;
      len_err_q <= len_err_d;
    end
  end

  assign tdo_o     = chain_sel ? sr_q[0] : 1'b0;
  assign len_err_o = len_err_q;

  for (genvar i = 0; i < N_GPIO; i++) begin : g_pad
    bsr_pad_mux u_pad_mux (
      .highz_i   (highz_en),
      .clamp_i   (clamp_en),
      .extest_i  (extest_select_i),
      .upd_o_i   (upd_o_q[i]),
      .upd_oe_i  (upd_oe_q[i]),
      .core_o_i  (core_o_i[i]),
      .core_oe_i (core_oe_i[i]),
      .pad_o_o   (pad_o[i]),
      .pad_oe_o  (pad_oe_o[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_bsr_chain.sv
// ============================================================================
// tb_bsr_chain : self-checking bench for bsr_chain (N_GPIO=15, N_DIN=18)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_bsr_chain;

  localparam int NG  = 15;
  localparam int ND  = 18;
  localparam int NP  = NG + ND;
  localparam int LEN = 3 * NG + ND + 1;
`ifdef BSR_CLAMP_EN
  localparam bit CL_EN = 1'b1;
`else
  localparam bit CL_EN = 1'b0;
`endif

  logic          tck = 1'b0;
  logic          rst, cap, sh, upd, sp, ex, cl, hz, tdi;
  logic [NP-1:0] pad_in;
  logic [NG-1:0] core_o, core_oe;
  logic          tdo;
  logic [NG-1:0] pad_o, pad_oe;
  logic          len_err;

  int vectors     = 0;
  int miscompares = 0;

  bsr_chain #(.N_GPIO(NG), .N_DIN(ND)) dut (
    .tck_i                   (tck),
    .test_logic_reset_i      (rst),
    .capture_dr_i            (cap),
    .shift_dr_i              (sh),
    .update_dr_i             (upd),
    .sample_preload_select_i (sp),
    .extest_select_i         (ex),
    .clamp_select_i          (cl),
    .highz_select_i          (hz),
    .tdi_i                   (tdi),
    .tdo_o                   (tdo),
    .pad_in_i                (pad_in),
    .core_o_i                (core_o),
    .core_oe_i               (core_oe),
    .pad_o                   (pad_o),
    .pad_oe_o                (pad_oe),
    .len_err_o               (len_err)
  );

  always #5 tck = ~tck;

  // Reference model: chain as a bit queue, element 0 is the bit seen on TDO
  bit            m_chain[$];
  int            m_cnt;
  logic [NG-1:0] m_upd_o, m_upd_oe;
  logic          m_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_chain.delete();
    for (int i = 0; i < LEN; i++) m_chain.push_back(1'b0);
    m_cnt    = 0;
    m_upd_o  = '0;
    m_upd_oe = '0;
    m_err    = 1'b0;
  endtask

  task automatic model_edge();
    if (rst) begin
      model_reset();
    end else if (sp || ex) begin
      if (cap) begin
        m_chain.delete();
        for (int i = 0; i < NP; i++) m_chain.push_back(pad_in[i]);
        for (int i = 0; i < NG; i++) m_chain.push_back(ex ? m_upd_o[i] : core_o[i]);
        for (int i = 0; i < NG; i++) m_chain.push_back(ex ? m_upd_oe[i] : core_oe[i]);
        m_chain.push_back(1'b0);
        m_cnt = 0;
        m_err = 1'b0;
      end else if (sh) begin
        void'(m_chain.pop_front());
        m_chain.push_back(tdi);
        if (m_cnt < LEN + 1) m_cnt++;
      end else if (upd) begin
        if (m_cnt != LEN) begin
          m_err = 1'b1;
        end else if (m_chain[LEN-1]) begin
          for (int i = 0; i < NG; i++) begin
            m_upd_o[i]  = m_chain[NP + i];
            m_upd_oe[i] = m_chain[NP + NG + i];
          end
        end
      end
    end
  endtask

  task automatic exp_pads(output logic [NG-1:0] po, output logic [NG-1:0] poe);
    po  = core_o;
    poe = core_oe;
    if (CL_EN && hz) begin
      po  = m_upd_o;
      poe = '0;
    end else if ((CL_EN && cl) || ex) begin
      po  = m_upd_o;
      poe = m_upd_oe;
    end
  endtask

  task automatic check_all();
    logic [NG-1:0] po, poe;
    exp_pads(po, poe);
    check("tdo", 64'(tdo), 64'((sp || ex) ? m_chain[0] : 1'b0));
    check("pad_o", 64'(pad_o), 64'(po));
    check("pad_oe", 64'(pad_oe), 64'(poe));
    check("len_err", 64'(len_err), 64'(m_err));
  endtask

  task automatic tick();
    model_edge();
    @(posedge tck);
    #1;
    check_all();
  endtask

  task automatic scan(input logic [63:0] data, input int nbits, input bit do_update);
    cap = 1'b1; tick(); cap = 1'b0;
    sh = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      tdi = data[i];
      tick();
    end
    sh = 1'b0; tdi = 1'b0;
    if (do_update) begin
      upd = 1'b1; tick(); upd = 1'b0;
    end
  endtask

  typedef struct {
    logic          hz, cl, ex, sp;
    logic [NG-1:0] exp_o, exp_oe;
  } mux_vec_t;

  mux_vec_t tv[8];

  initial begin
    #1_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] data, got;
    int          len;

    // pad_o/pad_oe expectations with upd_o=5A5A, upd_oe=7FFF, core 1234/00FF
    tv[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 15'h1234, 15'h00FF};
    tv[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 15'h5A5A, 15'h7FFF};
    tv[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 15'h1234, 15'h00FF};
    tv[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 15'h5A5A, CL_EN ? 15'h0000 : 15'h7FFF};
    tv[4] = '{1'b0, 1'b1, 1'b0, 1'b0, CL_EN ? 15'h5A5A : 15'h1234, CL_EN ? 15'h7FFF : 15'h00FF};
    tv[5] = '{1'b1, 1'b0, 1'b0, 1'b0, CL_EN ? 15'h5A5A : 15'h1234, CL_EN ? 15'h0000 : 15'h00FF};
    tv[6] = '{1'b1, 1'b1, 1'b0, 1'b1, CL_EN ? 15'h5A5A : 15'h1234, CL_EN ? 15'h0000 : 15'h00FF};
    tv[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 15'h5A5A, 15'h7FFF};

    rst = 1'b0; cap = 1'b0; sh = 1'b0; upd = 1'b0;
    sp = 1'b0; ex = 1'b0; cl = 1'b0; hz = 1'b0; tdi = 1'b0;
    pad_in = '0; core_o = 15'h2B3C; core_oe = 15'h4D5E;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    check("reset_pad_o_functional", 64'(pad_o), 64'(15'h2B3C));
    tick();
    tick();
    rst = 1'b0;
    tick();

    // EXTEST load
    ex = 1'b1;
    pad_in = {1'($urandom), 32'($urandom)};
    data = {1'b1, 15'h7FFF, 15'h5A5A, pad_in};
    scan(data, LEN, 1'b1);
    check("extest_pad_o", 64'(pad_o), 64'(15'h5A5A));
    check("extest_pad_oe", 64'(pad_oe), 64'(15'h7FFF));
    check("extest_len_err", 64'(len_err), 64'(1'b0));
    ex = 1'b0;

    // Pad mux table
    core_o = 15'h1234; core_oe = 15'h00FF;
    for (int i = 0; i < 8; i++) begin
      hz = tv[i].hz; cl = tv[i].cl; ex = tv[i].ex; sp = tv[i].sp;
      #1;
      check($sformatf("mux%0d_pad_o", i), 64'(pad_o), 64'(tv[i].exp_o));
      check($sformatf("mux%0d_pad_oe", i), 64'(pad_oe), 64'(tv[i].exp_oe));
    end
    hz = 1'b0; cl = 1'b0; ex = 1'b0; sp = 1'b0;

    // highz + extest, then drop highz in the same cycle
    @(posedge tck); #1;
    hz = 1'b1; ex = 1'b1; #1;
    check("prec_highz_oe", 64'(pad_oe), 64'(CL_EN ? 15'h0000 : 15'h7FFF));
    hz = 1'b0; #1;
    check("prec_drop_highz_oe", 64'(pad_oe), 64'(15'h7FFF));
    ex = 1'b0;

    // SAMPLE: observe captured bits on TDO
    sp = 1'b1;
    pad_in = 33'h1_2345_6789; core_o = 15'h0F0F; core_oe = 15'h3C5A;
    cap = 1'b1; tick(); cap = 1'b0;
    sh = 1'b1;
    for (int i = 0; i < LEN; i++) begin
      got[i] = tdo;
      tdi = 1'($urandom);
      tick();
    end
    sh = 1'b0;
    check("sample_tdo_stream", got, {1'b0, 15'h3C5A, 15'h0F0F, 33'h1_2345_6789});
    check("sample_pad_o", 64'(pad_o), 64'(15'h0F0F));
    check("sample_pad_oe", 64'(pad_oe), 64'(15'h3C5A));
    sp = 1'b0;

    // Short shift
    ex = 1'b1;
    scan({1'b1, 15'h7FFF, 15'h0000, 33'h0}, LEN - 1, 1'b1);
    check("short_len_err", 64'(len_err), 64'(1'b1));
    check("short_pad_o_held", 64'(pad_o), 64'(15'h5A5A));
    cap = 1'b1; tick(); cap = 1'b0;
    check("short_capture_clears", 64'(len_err), 64'(1'b0));

    // COMMIT=0
    scan({1'b0, 15'h7FFF, 15'h7FFF, 33'h0}, LEN, 1'b1);
    check("nocommit_pad_o", 64'(pad_o), 64'(15'h5A5A));
    check("nocommit_len_err", 64'(len_err), 64'(1'b0));

    // Over-long shift saturates and is rejected
    scan({1'b1, 15'h1111, 15'h2222, 33'h0}, LEN + 3, 1'b1);
    check("long_len_err", 64'(len_err), 64'(1'b1));
    ex = 1'b0;

    // Randomized scans with idle cycles and random modes
    for (int r = 0; r < 14; r++) begin
      sp = 1'($urandom); ex = (!sp) | 1'($urandom);
      hz = ($urandom % 4) == 0; cl = ($urandom % 4) == 0;
      data = {$urandom, $urandom};
      data[63] = (r % 3) != 0;
      len = LEN - 2 + int'($urandom % 5);
      if (r % 2 == 0) len = LEN;
      core_o = 15'($urandom); core_oe = 15'($urandom); pad_in = {1'($urandom), 32'($urandom)};
      cap = 1'b1; tick(); cap = 1'b0;
      for (int i = 0; i < len; i++) begin
        if (($urandom % 6) == 0) begin
          sh = 1'b0; tick();
        end
        sh = 1'b1; tdi = data[i];
        core_o = 15'($urandom);
        tick();
      end
      sh = 1'b0;
      upd = 1'b1; tick(); upd = 1'b0;
      tick();
    end

    // Fully random strobes and selects, including coincident strobes
    for (int c = 0; c < 250; c++) begin
      cap = ($urandom % 12) == 0; sh = ($urandom % 2) == 0; upd = ($urandom % 8) == 0;
      sp = ($urandom % 3) != 0; ex = ($urandom % 3) == 0;
      hz = ($urandom % 6) == 0; cl = ($urandom % 6) == 0;
      tdi = 1'($urandom);
      core_o = 15'($urandom); core_oe = 15'($urandom); pad_in = {1'($urandom), 32'($urandom)};
      tick();
    end
    cap = 1'b0; sh = 1'b0; upd = 1'b0; hz = 1'b0; cl = 1'b0; sp = 1'b0;

    // Reset in the middle of a scan aborts it
    ex = 1'b1;
    cap = 1'b1; tick(); cap = 1'b0;
    sh = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tdi = 1'($urandom);
      tick();
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("midreset_tdo", 64'(tdo), 64'(1'b0));
    check("midreset_pad_o", 64'(pad_o), 64'(15'h0000));
    check("midreset_pad_oe", 64'(pad_oe), 64'(15'h0000));
    check("midreset_len_err", 64'(len_err), 64'(1'b0));
    sh = 1'b0;
    tick();
    rst = 1'b0;
    upd = 1'b1; tick(); upd = 1'b0;
    check("postreset_len_err", 64'(len_err), 64'(1'b1));
    check("postreset_pad_o", 64'(pad_o), 64'(15'h0000));
    ex = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bsr_chain.md
BSR_CHAIN -- requirements
Module: bsr_chain

Interface
REQ-001 Parameter N_GPIO, default 15, number of bidirectional GPIO pads with OUT and OE cells.
REQ-002 Parameter N_DIN, default 18, number of input-only pads.
REQ-003 tck_i  in  1  JTAG TCK; all state changes on its rising edge.
REQ-004 test_logic_reset_i  in  1  reset, asynchronous, active-high.
REQ-005 capture_dr_i, shift_dr_i, update_dr_i  in  1 each  TAP state strobes, sampled on rising tck_i.
REQ-006 sample_preload_select_i, extest_select_i, clamp_select_i, highz_select_i  in  1 each  decoded instruction selects.
REQ-007 tdi_i  in  1  serial data in.
REQ-008 tdo_o  out  1  serial data out from the chain LSB.
REQ-009 pad_in_i  in  N_GPIO+N_DIN  pad input values; GPIO in bits [N_GPIO-1:0], DIN above them.
REQ-010 core_o_i, core_oe_i  in  N_GPIO each  functional core drive and enable.
REQ-011 pad_o, pad_oe_o  out  N_GPIO each  drive and enable to the pad ring.
REQ-012 len_err_o  out  1  sticky flag: an update was attempted after a wrong shift count.

Function
REQ-013 BSR_LEN SHALL be 3*N_GPIO+N_DIN+1 (64 at default); LSB-first order [IN | OUT | OE | COMMIT], with COMMIT at bit BSR_LEN-1.
REQ-014 Chain-select = sample_preload_select_i | extest_select_i.
REQ-015 On capture_dr_i with chain-select: IN slice <= pad_in_i; COMMIT <= 0; shift count <= 0; len_err_o <= 0.
REQ-016 On that capture, OUT/OE slices SHALL load core_o_i/core_oe_i under SAMPLE_PRELOAD and the update registers (upd_o/upd_oe) under EXTEST.
REQ-017 On shift_dr_i with chain-select: shift right one bit; tdi_i enters bit BSR_LEN-1; count increments, saturating at BSR_LEN+1.
REQ-018 On update_dr_i with chain-select, count==BSR_LEN and COMMIT==1: upd_o <= OUT slice and upd_oe <= OE slice, same edge.
REQ-019 On update_dr_i with chain-select and count!=BSR_LEN: no load; len_err_o <= 1.
REQ-020 On update_dr_i with count==BSR_LEN and COMMIT==0: no load and no error.
REQ-021 With coincident strobes, only the highest-priority one acts: capture > shift > update.
REQ-022 If both chain selects are high, EXTEST semantics SHALL apply.
REQ-023 tdo_o = shift-register bit 0 when chain-select is high, else 0; combinational, zero added latency.
REQ-024 Pad-mux precedence: highz (pad_oe_o=0, pad_o=upd_o) > clamp (upd_o/upd_oe) > extest (upd_o/upd_oe) > functional (core_o_i/core_oe_i).
REQ-025 The pad mux SHALL be combinational from the select inputs and registered update values; a select change takes effect the same cycle.
REQ-026 With no select active, the shift register, count and update registers SHALL hold.

Reset
REQ-027 Asserting test_logic_reset_i SHALL immediately clear the shift register, count, upd_o, upd_oe and len_err_o to 0.
REQ-028 During and after reset, tdo_o=0 and pads follow the functional path (selects low).
REQ-029 Reset asserted mid-shift SHALL abort the scan; a following update_dr_i without a new capture SHALL set len_err_o and load nothing.

Configuration
REQ-030 Macro BSR_CLAMP_EN: when defined, clamp_select_i and highz_select_i behave per REQ-024.
REQ-031 When BSR_CLAMP_EN is undefined, those ports SHALL remain present but ignored; precedence becomes extest > functional.

Structure
REQ-032 Package bsr_pkg SHALL hold the default N_GPIO/N_DIN, the BSR_LEN function and slice LO/HI offset functions, and the count width clog2(BSR_LEN+2).
REQ-033 One sub-module, bsr_pad_mux (per-pad precedence mux, N_GPIO instances via generate); everything else lives in bsr_chain.

Verification (N_GPIO=15, N_DIN=18)
REQ-034 EXTEST: capture, shift 64 bits with OUT=15'h5A5A, OE=15'h7FFF, COMMIT=1, update -> pad_o=15'h5A5A, pad_oe_o=15'h7FFF, len_err_o=0.
REQ-035 SAMPLE: pad_in_i=33'h1_2345_6789, core_o_i=15'h0F0F, capture, shift 64 -> tdo_o yields those bits LSB-first then core_oe_i; pads stay functional.
REQ-036 Short shift: capture, shift 63, update -> upd_o unchanged, len_err_o=1; next capture clears it.
REQ-037 COMMIT=0: full 64-bit shift with OUT=15'h7FFF, update -> upd_o unchanged, len_err_o=0.
REQ-038 Precedence (BSR_CLAMP_EN defined): upd_oe=15'h7FFF, raise highz_select_i and extest_select_i together -> pad_oe_o=0; drop highz -> pad_oe_o=15'h7FFF same cycle.
REQ-039 Reset at shift bit 30 -> all outputs 0 immediately; update without capture -> len_err_o=1, no load.
